imem_program_loader: RTL and testbench

//  Byte-stream loader that writes a program into the pipeline's instruction memory before execution.

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_byte_assembler.sv | 41 ++++
 rtl/imem_program_loader.sv | 140 ++++++++++++++
 tb/tb_imem_program_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg -- shared types and constants for the instruction-memory
// program loader.
//   state_t    : loader FSM states (S_CSUM is only reachable when
//                IMEM_LOADER_CHECKSUM_EN is defined)
//   HDR_BYTES  : bytes in the word-count header
//   WORD_BYTES : bytes per instruction word
package imem_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_WRITE,
      S_CSUM,
      S_DONE,
      S_ERROR
   } state_t;

   localparam int HDR_BYTES  = 2;
   localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_byte_assembler.sv
// imem_byte_assembler -- packs an MSB-first byte stream into 32-bit words.
// Ports:
//   i_clock, i_reset  : clock, async active-high reset
//   i_clear           : synchronous clear of word and byte counter
//   i_byte_en         : a byte is consumed this cycle
//   i_byte            : byte value
//   o_word            : shift register contents (complete while in WRITE)
//   o_word_ready      : high on the handshake that completes a word
module imem_byte_assembler
   import imem_loader_pkg::*;
(
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_clear,
   input  logic        i_byte_en,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic        o_word_ready
);

   logic [31:0] r_word;
   logic [1:0]  r_cnt;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_word <= '0;
         r_cnt  <= '0;
      end else if (i_clear) begin
         r_word <= '0;
         r_cnt  <= '0;
      end else if (i_byte_en) begin
         r_word <= {r_word[23:0], i_byte};
         r_cnt  <= r_cnt + 2'd1;
      end
   end

   assign o_word       = r_word;
   // Counter wraps to 0 on its own after the last byte of a word.
   assign o_word_ready = i_byte_en && (r_cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_program_loader.sv
// imem_program_loader -- loads a program from a byte stream into imem while
// holding the CPU. Stream: 16-bit word count, then count 32-bit words, all
// MSB first. Optional trailing XOR checksum byte when the macro
// IMEM_LOADER_CHECKSUM_EN is defined.
// Ports:
//   i_clock, i_reset         : clock, async active-high reset
//   i_start                  : begins a load from IDLE/DONE/ERROR
//   i_in_valid, i_in_data    : byte source
//   o_in_ready               : byte accepted when valid && ready
//   o_imem_we/addr/wdata     : imem write port, one strobe per word
//   o_cpu_hold               : keep the CPU held (low only in DONE)
//   o_done, o_error          : level status
module imem_program_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic              i_in_valid,
   input  logic [7:0]        i_in_data,
   output logic              o_in_ready,
   output logic              o_imem_we,
   output logic [ADDR_W-1:0] o_imem_addr,
   output logic [31:0]       o_imem_wdata,
   output logic              o_cpu_hold,
   output logic              o_done,
   output logic              o_error
);

   localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

   state_t            r_state, w_next;
   logic              r_hdr_cnt;
   logic [15:0]       r_count;
   logic [15:0]       r_index;
   logic [ADDR_W-1:0] r_addr_q;
   logic [31:0]       r_wdata_q;
   logic              w_accept, w_start_ok, w_word_ready;
   logic [15:0]       w_count;
   logic [31:0]       w_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        r_xor;
`endif

   assign w_accept   = i_in_valid && o_in_ready;
   assign w_start_ok = i_start && (r_state == S_IDLE || r_state == S_DONE ||
                                   r_state == S_ERROR);
   // Count as it will be once the current header byte lands.
   assign w_count    = {r_count[7:0], i_in_data};

   imem_byte_assembler u_asm (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_clear      (w_start_ok),
      .i_byte_en    (w_accept && r_state == S_DATA),
      .i_byte       (i_in_data),
      .o_word       (w_word),
      .o_word_ready (w_word_ready)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERROR:
            if (i_start) w_next = S_HDR;
         S_HDR:
            if (w_accept && r_hdr_cnt == 1'(HDR_BYTES - 1)) begin
               if (w_count == 16'd0)              w_next = S_DONE;
               else if ({1'b0, w_count} > DEPTH)  w_next = S_ERROR;
               else                               w_next = S_DATA;
            end
         S_DATA:
            if (w_word_ready) w_next = S_WRITE;
         S_WRITE:
            if (r_index + 16'd1 == r_count) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               w_next = S_CSUM;
`else
               w_next = S_DONE;
`endif
            end else begin
               w_next = S_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM:
            if (w_accept) w_next = (i_in_data == r_xor) ? S_DONE : S_ERROR;
`endif
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_hdr_cnt <= 1'b0;
         r_count   <= '0;
         r_index   <= '0;
         r_addr_q  <= '0;
         r_wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_xor     <= '0;
`endif
      end else begin
         r_state <= w_next;
         if (w_start_ok) begin
            r_hdr_cnt <= 1'b0;
            r_index   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor     <= '0;
`endif
         end
         if (r_state == S_HDR && w_accept) begin
            r_hdr_cnt <= 1'b1;
            r_count   <= w_count;
         end
         // Capture the written address/data so the port holds them after WRITE.
         if (r_state == S_WRITE) begin
            r_index   <= r_index + 16'd1;
            r_addr_q  <= r_index[ADDR_W-1:0];
            r_wdata_q <= w_word;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (r_state == S_DATA && w_accept) r_xor <= r_xor ^ i_in_data;
`endif
      end
   end

   always_comb begin
      o_in_ready   = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CSUM);
      o_imem_we    = (r_state == S_WRITE);
      o_imem_addr  = o_imem_we ? r_index[ADDR_W-1:0] : r_addr_q;
      o_imem_wdata = o_imem_we ? w_word : r_wdata_q;
      o_cpu_hold   = (r_state != S_DONE);
      o_done       = (r_state == S_DONE);
      o_error      = (r_state == S_ERROR);
   end

endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader -- directed self-checking bench for the loader.
// Checksum scenarios are compiled in when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_program_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready, we, hold, done, error;
   logic [7:0]  addr;
   logic [31:0] wdata;

   int checks = 0;
   int errors = 0;

   logic [7:0]  wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [7:0]  s1 [10] = '{8'h00, 8'h02, 8'h20, 8'h10, 8'h00, 8'h05,
                            8'h02, 8'h11, 8'h90, 8'h20};

   imem_program_loader #(.ADDR_W(8)) dut (
      .i_clock      (clk),
      .i_reset      (rst),
      .i_start      (start),
      .i_in_valid   (in_valid),
      .i_in_data    (in_data),
      .o_in_ready   (in_ready),
      .o_imem_we    (we),
      .o_imem_addr  (addr),
      .o_imem_wdata (wdata),
      .o_cpu_hold   (hold),
      .o_done       (done),
      .o_error      (error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (we === 1'b1) begin
         wr_addr_q.push_back(addr);
         wr_data_q.push_back(wdata);
      end
   end

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      wr_addr_q.delete();
      wr_data_q.delete();
   endtask

   // Presents one byte after 'gap' idle cycles and returns just after the
   // edge that consumes it.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      repeat (gap) begin @(negedge clk); in_valid = 1'b0; end
      @(negedge clk); in_valid = 1'b1; in_data = b; n = 0;
      while (in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) begin
         checks++; errors++;
         $display("FAIL handshake_timeout byte=%h in_ready=%b want 1", b, in_ready);
      end
      @(posedge clk); #1 in_valid = 1'b0;
   endtask

   task automatic run_s1(input int gap, input string tag);
      pulse_start();
      for (int i = 0; i < 10; i++) send_byte(s1[i], gap);
      @(negedge clk);
      checks++;
      if (we !== 1'b1 || addr !== 8'd1 || wdata !== 32'h02119020) begin
         errors++;
         $display("FAIL %s_last_write we=%b addr=%h data=%h want 1/01/02119020", tag, we, addr, wdata);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'h96, gap);
`endif
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || hold !== 1'b0 || error !== 1'b0 || we !== 1'b0) begin
         errors++;
         $display("FAIL %s_done done=%b hold=%b err=%b we=%b want 1/0/0/0", tag, done, hold, error, we);
      end
      checks++;
      if (addr !== 8'd1 || wdata !== 32'h02119020) begin
         errors++;
         $display("FAIL %s_hold_port addr=%h data=%h want 01/02119020", tag, addr, wdata);
      end
      checks++;
      if (wr_addr_q.size() != 2) begin
         errors++;
         $display("FAIL %s_write_count got=%0d want 2", tag, wr_addr_q.size());
      end else begin
         checks++;
         if (wr_addr_q[0] !== 8'd0 || wr_data_q[0] !== 32'h20100005 ||
             wr_addr_q[1] !== 8'd1 || wr_data_q[1] !== 32'h02119020) begin
            errors++;
            $display("FAIL %s_writes got %h:%h %h:%h want 00:20100005 01:02119020",
                     tag, wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || we !== 1'b0 || addr !== 8'd0 || wdata !== 32'd0 ||
          hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
         errors++;
         $display("FAIL reset_state rdy=%b we=%b addr=%h data=%h hold=%b done=%b err=%b want 0/0/00/0/1/0/0",
                  in_ready, we, addr, wdata, hold, done, error);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || hold !== 1'b1) begin
         errors++;
         $display("FAIL idle_state rdy=%b hold=%b want 0/1", in_ready, hold);
      end
   endtask

   task automatic test_basic();
      run_s1(0, "basic");
   endtask

   task automatic test_zero_count();
      pulse_start();
      checks++;
      if (hold !== 1'b1 || done !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL restart_hold hold=%b done=%b rdy=%b want 1/0/1", hold, done, in_ready);
      end
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || hold !== 1'b0 || wr_addr_q.size() != 0) begin
         errors++;
         $display("FAIL zero_count done=%b hold=%b writes=%0d want 1/0/0", done, hold, wr_addr_q.size());
      end
   endtask

   task automatic test_overflow();
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      @(negedge clk);
      checks++;
      if (error !== 1'b1 || in_ready !== 1'b0 || hold !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL overflow err=%b rdy=%b hold=%b done=%b want 1/0/1/0", error, in_ready, hold, done);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (error !== 1'b1 || wr_addr_q.size() != 0) begin
         errors++;
         $display("FAIL overflow_sticky err=%b writes=%0d want 1/0", error, wr_addr_q.size());
      end
      run_s1(0, "recover");
   endtask

   task automatic test_toggle();
      run_s1(1, "toggle");
   endtask

   task automatic test_reset_midload();
      pulse_start();
      for (int i = 0; i < 5; i++) send_byte(s1[i], 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0 || we !== 1'b0 || addr !== 8'd0 || wdata !== 32'd0 ||
          hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
         errors++;
         $display("FAIL midload_reset rdy=%b we=%b addr=%h data=%h hold=%b done=%b err=%b want 0/0/00/0/1/0/0",
                  in_ready, we, addr, wdata, hold, done, error);
      end
      @(negedge clk); rst = 1'b0;
      run_s1(0, "after_reset");
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum_bad();
      pulse_start();
      for (int i = 0; i < 10; i++) send_byte(s1[i], 0);
      send_byte(8'h97, 0);
      @(negedge clk);
      checks++;
      if (error !== 1'b1 || hold !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL csum_bad err=%b hold=%b done=%b want 1/1/0", error, hold, done);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_zero_count();
      test_overflow();
      test_toggle();
      test_reset_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum_bad();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

endmodule
